// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_pkg
// Description : Shared types and helpers for JK flip-flop drivers.
//               - jk_state_e : sequencer FSM state encoding
//               - jk_excite  : JK excitation table, (q, t, use_toggle) -> {j,k}
// Revision    : 1.0 - initial release
// ============================================================================
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_HOLD  = 2'd3
  } jk_state_e;

  // Returns {j,k} that moves a JK flop from q to t on the next edge.
  // Bits already at target get J=K=0 so the flop simply holds.
  function automatic logic [1:0] jk_excite(input logic q, input logic t,
                                           input logic use_toggle);
    logic [1:0] v_jk;
    v_jk = 2'b00;
    if (q != t) begin
      if (use_toggle)
        v_jk = 2'b11;
      else if (t)
        v_jk = 2'b10;
      else
        v_jk = 2'b01;
    end
    return v_jk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jk_seq_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : jk_seq_driver_if
// Description : Target push channel of jk_seq_driver (valid/ready).
//               in_valid  : target entry offered
//               in_ready  : driver FIFO can accept
//               in_target : desired flop pattern (WIDTH)
//               in_hold   : idle cycles after the check (HOLD_W), 0 = none
//               master modport: sequencer / CPU side
//               slave  modport: jk_seq_driver side
// Revision    : 1.0 - initial release
// ============================================================================
interface jk_seq_driver_if #(
  parameter int WIDTH  = 4,
  parameter int HOLD_W = 4
) ();

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_target;
  logic [HOLD_W-1:0] in_hold;

  modport master (
    output in_valid,
    output in_target,
    output in_hold,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_target,
    input  in_hold,
    output in_ready
  );

endinterface
`default_nettype wire

// File: rtl/jk_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : jk_seq_fifo
// Description : Synchronous FIFO with show-ahead read data.
//               Pointers carry one extra wrap bit so full and empty are
//               distinguished without a separate counter.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-low; empties the FIFO
//               push  - write wdata (ignored while full)
//               wdata - write data (DATA_W)
//               pop   - advance read pointer (ignored while empty)
//               rdata - current head entry
//               full  - no free entries
//               empty - no stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module jk_seq_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              push,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic              pop,
  output logic      [DATA_W-1:0] rdata,
  output logic                   full,
  output logic                   empty
);

  localparam int                c_addr_w  = $clog2(DEPTH);
  localparam logic [c_addr_w:0] c_ptr_one = (c_addr_w + 1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_addr_w:0] r_wr_ptr;
  logic [c_addr_w:0] r_rd_ptr;
  logic              w_push_ok;
  logic              w_pop_ok;

  // Same index with different wrap bits means the writer lapped the reader.
  assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                 (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);

  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign rdata     = r_mem[r_rd_ptr[c_addr_w-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop_ok)
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr[c_addr_w-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/jk_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : jk_seq_driver
// Description : Steps an external bank of WIDTH JK flops through a queued
//               sequence of target patterns. Each target gets a one-cycle
//               J/K excitation (from the fed-back Q), a one-cycle check and
//               an optional hold of in_hold cycles.
// Ports       : clk          - clock, rising edge
//               reset        - asynchronous, active-low
//               in_if        - target push channel (slave modport)
//               q_fb         - Q outputs of the driven flop bank
//               j, k         - registered J/K drive
//               busy         - high whenever the FSM is not IDLE
//               done         - one-cycle pulse in the cycle after CHECK
//               mismatch     - sticky check-failure flag
//               mismatch_clr - synchronous clear of mismatch (set wins)
// Revision    : 1.0 - initial release
// ============================================================================
module jk_seq_driver
  import jk_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 4,
  parameter int HOLD_W     = 4,
  parameter int USE_TOGGLE = 0
) (
  input  wire logic             clk,
  input  wire logic             reset,
  jk_seq_driver_if.slave        in_if,
  input  wire logic [WIDTH-1:0] q_fb,
  output logic      [WIDTH-1:0] j,
  output logic      [WIDTH-1:0] k,
  output logic                  busy,
  output logic                  done,
  output logic                  mismatch,
  input  wire logic             mismatch_clr
);

  localparam int                c_fifo_w   = WIDTH + HOLD_W;
  localparam logic [HOLD_W-1:0] c_hold_one = HOLD_W'(1);
  localparam logic              c_toggle   = (USE_TOGGLE != 0);

  // --------------------------------------------------------------------------
  // Target FIFO
  // --------------------------------------------------------------------------
  logic [c_fifo_w-1:0] w_fifo_wdata;
  logic [c_fifo_w-1:0] w_fifo_rdata;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_pop;
  logic [WIDTH-1:0]    w_head_target;
  logic [HOLD_W-1:0]   w_head_hold;

  assign w_fifo_wdata   = {in_if.in_target, in_if.in_hold};
  assign w_head_target  = w_fifo_rdata[c_fifo_w-1:HOLD_W];
  assign w_head_hold    = w_fifo_rdata[HOLD_W-1:0];
  // Ready depends only on the stored level, never on a same-cycle pop.
  assign in_if.in_ready = !w_fifo_full;

  jk_seq_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (c_fifo_w)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_if.in_valid),
    .wdata (w_fifo_wdata),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // --------------------------------------------------------------------------
  // Excitation for the FIFO head against the current flop state
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_load_j;
  logic [WIDTH-1:0] w_load_k;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_excite
    logic [1:0] w_jk_bit;
    assign w_jk_bit     = jk_excite(q_fb[gi], w_head_target[gi], c_toggle);
    assign w_load_j[gi] = w_jk_bit[1];
    assign w_load_k[gi] = w_jk_bit[0];
  end

  // --------------------------------------------------------------------------
  // FSM and datapath registers
  // --------------------------------------------------------------------------
  jk_state_e         r_state;
  jk_state_e         w_state_nxt;
  logic [WIDTH-1:0]  r_j;
  logic [WIDTH-1:0]  w_j_nxt;
  logic [WIDTH-1:0]  r_k;
  logic [WIDTH-1:0]  w_k_nxt;
  logic [WIDTH-1:0]  r_target;
  logic [WIDTH-1:0]  w_target_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [HOLD_W-1:0] r_cnt;
  logic [HOLD_W-1:0] w_cnt_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_mismatch;
  logic              w_mismatch_nxt;
  logic              w_advance;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_j        <= '0;
      r_k        <= '0;
      r_target   <= '0;
      r_hold     <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_j        <= w_j_nxt;
      r_k        <= w_k_nxt;
      r_target   <= w_target_nxt;
      r_hold     <= w_hold_nxt;
      r_cnt      <= w_cnt_nxt;
      r_done     <= w_done_nxt;
      r_mismatch <= w_mismatch_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_j_nxt        = '0;
    w_k_nxt        = '0;
    w_target_nxt   = r_target;
    w_hold_nxt     = r_hold;
    w_cnt_nxt      = r_cnt;
    w_done_nxt     = 1'b0;
    w_mismatch_nxt = r_mismatch && !mismatch_clr;
    w_pop          = 1'b0;
    // w_advance marks "this step is finished": start the next queued target
    // or fall back to IDLE. IDLE simply retries every cycle.
    w_advance      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_advance = 1'b1;
      end
      ST_DRIVE: begin
        // J/K default to 0 above, so they drop on the edge leaving DRIVE.
        w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        w_done_nxt = 1'b1;
        // A failing check overrides a simultaneous clear.
        if (q_fb != r_target)
          w_mismatch_nxt = 1'b1;
        if (r_hold == '0) begin
          w_advance = 1'b1;
        end else begin
          w_cnt_nxt   = r_hold;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_cnt == c_hold_one)
          w_advance = 1'b1;
        else
          w_cnt_nxt = r_cnt - c_hold_one;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_advance) begin
      if (!w_fifo_empty) begin
        w_pop        = 1'b1;
        w_target_nxt = w_head_target;
        w_hold_nxt   = w_head_hold;
        w_j_nxt      = w_load_j;
        w_k_nxt      = w_load_k;
        w_state_nxt  = ST_DRIVE;
      end else begin
        w_state_nxt  = ST_IDLE;
      end
    end
  end

  assign j        = r_j;
  assign k        = r_k;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign mismatch = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_jk_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_seq_driver
// Description : Self-checking bench for jk_seq_driver. Two instances:
//               u_dut0 in set/reset mode, u_dut1 in toggle mode. Each drives
//               a behavioural JK flop bank whose Q feeds back as q_fb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_seq_driver;

  logic clk;
  logic reset;

  jk_seq_driver_if #(.WIDTH(4), .HOLD_W(4)) if0 ();
  jk_seq_driver_if #(.WIDTH(4), .HOLD_W(4)) if1 ();

  logic [3:0] q_fb0, q_fb1, j0, k0, j1, k1;
  logic       busy0, done0, mm0, clr0;
  logic       busy1, done1, mm1, clr1;

  // Behavioural flop banks (the "external" JK flops)
  logic [3:0] bank0, bank1;
  logic       pre_en0, pre_en1;
  logic [3:0] pre_val0, pre_val1;
  logic       stuck0;
  logic [3:0] stuck_val0;

  int cyc;
  int n_cmp;
  int n_err;

  jk_seq_driver #(.WIDTH(4), .DEPTH(4), .HOLD_W(4), .USE_TOGGLE(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_if(if0), .q_fb(q_fb0), .j(j0), .k(k0),
    .busy(busy0), .done(done0), .mismatch(mm0), .mismatch_clr(clr0)
  );

  jk_seq_driver #(.WIDTH(4), .DEPTH(4), .HOLD_W(4), .USE_TOGGLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_if(if1), .q_fb(q_fb1), .j(j1), .k(k1),
    .busy(busy1), .done(done1), .mismatch(mm1), .mismatch_clr(clr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // JK characteristic: Qn = J&~Q | ~K&Q
  always @(posedge clk) begin
    if (pre_en0) bank0 <= pre_val0;
    else         bank0 <= (j0 & ~bank0) | (~k0 & bank0);
    if (pre_en1) bank1 <= pre_val1;
    else         bank1 <= (j1 & ~bank1) | (~k1 & bank1);
  end

  assign q_fb0 = stuck0 ? stuck_val0 : bank0;
  assign q_fb1 = bank1;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload0(input logic [3:0] v);
    pre_en0 = 1'b1; pre_val0 = v; tick(); pre_en0 = 1'b0;
  endtask

  task automatic push0(input logic [3:0] t, input logic [3:0] h);
    if0.in_valid = 1'b1; if0.in_target = t; if0.in_hold = h;
    tick();
    if0.in_valid = 1'b0;
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (busy0 && n < 100) begin tick(); n++; end
    n_cmp++;
    if (busy0) begin n_err++; $display("FAIL idle_timeout: busy=%b required 0", busy0); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_cmp++; if (j0 !== 4'b0000) begin n_err++; $display("FAIL reset_j: got %b required 0000", j0); end
    n_cmp++; if (k0 !== 4'b0000) begin n_err++; $display("FAIL reset_k: got %b required 0000", k0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy0); end
    n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", done0); end
    n_cmp++; if (mm0 !== 1'b0) begin n_err++; $display("FAIL reset_mismatch: got %b required 0", mm0); end
    n_cmp++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", if0.in_ready); end
    reset = 1'b1;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_basic();
    preload0(4'b0000);
    push0(4'b1010, 4'd0);                       // edge N
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %b required 0", busy0); end
    tick();                                     // after N+1: DRIVE
    n_cmp++; if (j0 !== 4'b1010) begin n_err++; $display("FAIL basic_j: got %b required 1010", j0); end
    n_cmp++; if (k0 !== 4'b0000) begin n_err++; $display("FAIL basic_k: got %b required 0000", k0); end
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b required 1", busy0); end
    tick();                                     // after N+2: CHECK
    n_cmp++; if ({j0, k0} !== 8'h00) begin n_err++; $display("FAIL basic_jk_clear: got j=%b k=%b required 0", j0, k0); end
    n_cmp++; if (q_fb0 !== 4'b1010) begin n_err++; $display("FAIL basic_bank: got %b required 1010", q_fb0); end
    tick();                                     // after N+3
    n_cmp++; if (done0 !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b required 1", done0); end
    n_cmp++; if (mm0 !== 1'b0) begin n_err++; $display("FAIL basic_mismatch: got %b required 0", mm0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL basic_back_idle: got %b required 0", busy0); end
    tick();
    n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b required 0", done0); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_toggle();
    pre_en1 = 1'b1; pre_val1 = 4'b1100; tick(); pre_en1 = 1'b0;
    if1.in_valid = 1'b1; if1.in_target = 4'b0110; if1.in_hold = 4'd0;
    tick();
    if1.in_valid = 1'b0;
    tick();
    n_cmp++; if (j1 !== 4'b1010) begin n_err++; $display("FAIL toggle_j: got %b required 1010", j1); end
    n_cmp++; if (k1 !== 4'b1010) begin n_err++; $display("FAIL toggle_k: got %b required 1010", k1); end
    tick();
    n_cmp++; if (q_fb1 !== 4'b0110) begin n_err++; $display("FAIL toggle_bank: got %b required 0110", q_fb1); end
    tick();
    n_cmp++; if (done1 !== 1'b1) begin n_err++; $display("FAIL toggle_done: got %b required 1", done1); end
    n_cmp++; if (mm1 !== 1'b0) begin n_err++; $display("FAIL toggle_mismatch: got %b required 0", mm1); end
  endtask

  // --------------------------------------------------------------------------
  // Entry 0 holds 15 cycles so the next five pile up in the FIFO.
  task automatic test_back_to_back();
    logic [3:0] tgt [6];
    logic [3:0] hld [6];
    logic [3:0] exp_q[$];
    logic [3:0] t;
    int drv[$];
    int n_acc = 0;
    int n_done = 0;
    int n = 0;
    bit saw_full = 0;
    tgt = '{4'b1111, 4'b0101, 4'b1010, 4'b0101, 4'b1010, 4'b0101};
    hld = '{4'd15, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    preload0(4'b0000);
    while ((n_done < 6) && (n < 120)) begin
      if (done0) begin
        t = exp_q.pop_front(); n_done++;
        n_cmp++; if (q_fb0 !== t) begin n_err++; $display("FAIL b2b_order: bank %b required %b", q_fb0, t); end
      end
      if ((j0 | k0) != 4'b0000) drv.push_back(cyc);
      if (n_acc < 6) begin
        if0.in_valid = 1'b1; if0.in_target = tgt[n_acc]; if0.in_hold = hld[n_acc];
        if (if0.in_ready) begin
          exp_q.push_back(tgt[n_acc]); n_acc++;
        end else if (!saw_full) begin
          saw_full = 1;
          n_cmp++; if (n_acc != 5) begin n_err++; $display("FAIL b2b_full_count: accepted %0d before ready low, required 5", n_acc); end
        end
      end else begin
        if0.in_valid = 1'b0;
      end
      tick(); n++;
    end
    if0.in_valid = 1'b0;
    n_cmp++; if (!saw_full) begin n_err++; $display("FAIL b2b_ready_drop: in_ready never low, required low"); end
    n_cmp++; if (n_done != 6) begin n_err++; $display("FAIL b2b_completed: got %0d required 6", n_done); end
    n_cmp++;
    if (drv.size() != 6) begin
      n_err++; $display("FAIL b2b_drive_count: got %0d required 6", drv.size());
    end else begin
      if (drv[1] - drv[0] != 17) begin n_err++; $display("FAIL b2b_gap0: got %0d required 17", drv[1] - drv[0]); end
      for (int i = 2; i < 6; i++) begin
        n_cmp++;
        if (drv[i] - drv[i-1] != 4) begin n_err++; $display("FAIL b2b_gap%0d: got %0d required 4", i, drv[i] - drv[i-1]); end
      end
    end
    wait_idle0();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_mismatch();
    int n;
    preload0(4'b0000);
    stuck0 = 1'b1; stuck_val0 = 4'b0000;
    push0(4'b0001, 4'd0);
    tick(); tick(); tick();
    n_cmp++; if (done0 !== 1'b1) begin n_err++; $display("FAIL mm_done: got %b required 1", done0); end
    n_cmp++; if (mm0 !== 1'b1) begin n_err++; $display("FAIL mm_set: got %b required 1", mm0); end
    stuck0 = 1'b0;                              // bank is now 0001
    wait_idle0();
    push0(4'b0011, 4'd1);                       // passing step
    n = 0;
    while (!done0 && n < 20) begin tick(); n++; end
    n_cmp++; if (done0 !== 1'b1) begin n_err++; $display("FAIL mm_pass_done: got %b required 1", done0); end
    n_cmp++; if (mm0 !== 1'b1) begin n_err++; $display("FAIL mm_sticky: got %b required 1", mm0); end
    wait_idle0();
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    n_cmp++; if (mm0 !== 1'b0) begin n_err++; $display("FAIL mm_clear: got %b required 0", mm0); end
    stuck0 = 1'b1;
    push0(4'b0100, 4'd0);                       // edge N
    tick(); tick();                             // after N+2: CHECK cycle
    clr0 = 1'b1;
    tick();                                     // edge N+3: clear and failure together
    clr0 = 1'b0;
    n_cmp++; if (mm0 !== 1'b1) begin n_err++; $display("FAIL mm_set_wins: got %b required 1", mm0); end
    stuck0 = 1'b0;
    wait_idle0();
    clr0 = 1'b1; tick(); clr0 = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    logic [3:0] exp_q[$];
    logic [3:0] t;
    int n_push = 0;
    int n_done = 0;
    int n = 0;
    preload0(4'($urandom));
    while ((n_done < 24) && (n < 800)) begin
      if (done0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rnd_done: unexpected done, queue empty");
        end else begin
          t = exp_q.pop_front(); n_done++;
          if (q_fb0 !== t) begin n_err++; $display("FAIL rnd_bank: got %b required %b", q_fb0, t); end
        end
        n_cmp++; if (mm0 !== 1'b0) begin n_err++; $display("FAIL rnd_mismatch: got %b required 0", mm0); end
      end
      if ((j0 | k0) != 4'b0000) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rnd_drive: j=%b k=%b with nothing queued", j0, k0);
        end else begin
          t = exp_q[0];
          if ({j0, k0} !== {t & ~q_fb0, ~t & q_fb0})
            begin n_err++; $display("FAIL rnd_excite: got j=%b k=%b required j=%b k=%b", j0, k0, t & ~q_fb0, ~t & q_fb0); end
        end
      end
      if ((n_push < 24) && ($urandom_range(0, 1) == 1)) begin
        if0.in_valid = 1'b1; if0.in_target = 4'($urandom); if0.in_hold = 4'($urandom_range(0, 3));
        if (if0.in_ready) begin exp_q.push_back(if0.in_target); n_push++; end
      end else begin
        if0.in_valid = 1'b0;
      end
      tick(); n++;
    end
    if0.in_valid = 1'b0;
    n_cmp++; if (n_done != 24) begin n_err++; $display("FAIL rnd_completed: got %0d required 24", n_done); end
    wait_idle0();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_drive();
    int act = 0;
    preload0(4'b0000);
    if0.in_valid = 1'b1; if0.in_target = 4'b0011; if0.in_hold = 4'd0;
    tick();                                     // edge N: first entry
    if0.in_target = 4'b1100;
    tick();                                     // edge N+1: DRIVE, second queued
    if0.in_valid = 1'b0;
    n_cmp++; if (j0 !== 4'b0011) begin n_err++; $display("FAIL rst_pre_j: got %b required 0011", j0); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({j0, k0} !== 8'h00) begin n_err++; $display("FAIL rst_async_jk: got j=%b k=%b required 0", j0, k0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL rst_async_busy: got %b required 0", busy0); end
    n_cmp++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_async_ready: got %b required 1", if0.in_ready); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy0 || ((j0 | k0) != 4'b0000)) act++;
    end
    n_cmp++; if (act != 0) begin n_err++; $display("FAIL rst_queue_lost: %0d active cycles required 0", act); end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    cyc = 0; n_cmp = 0; n_err = 0;
    reset = 1'b0;
    if0.in_valid = 1'b0; if0.in_target = '0; if0.in_hold = '0;
    if1.in_valid = 1'b0; if1.in_target = '0; if1.in_hold = '0;
    clr0 = 1'b0; clr1 = 1'b0;
    pre_en0 = 1'b1; pre_val0 = '0; pre_en1 = 1'b1; pre_val1 = '0;
    stuck0 = 1'b0; stuck_val0 = '0;
    @(negedge clk);
    pre_en0 = 1'b0; pre_en1 = 1'b0;

    test_reset();
    test_basic();
    test_toggle();
    test_back_to_back();
    test_mismatch();
    test_random();
    test_reset_mid_drive();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
